// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD hours/minutes/seconds timekeeper with button-driven set mode
module time_keeper #(
  parameter bit FORMAT_24H = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       blink,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       day_tick
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    ILLEGAL = 2'd3
  } mode_t;

  // 12-hour clocks start at 12 AM, 24-hour clocks at 00.
  localparam logic [7:0] HOUR_RESET = FORMAT_24H ? 8'h00 : 8'h12;

  mode_t      state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       pm_q, pm_d;
  logic       day_q, day_d;

  // Add one to a packed-BCD pair; the caller handles the field's wrap point.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Advance the hour field, returning {pm, hour}; shared by RUN carry and SET_HR.
  function automatic logic [8:0] hour_step(input logic [7:0] h, input logic p);
    if (FORMAT_24H)
      return {1'b0, (h == 8'h23) ? 8'h00 : bcd_inc(h)};
    else if (h == 8'h12)
      return {p, 8'h01};
    else if (h == 8'h11)
      return {~p, 8'h12};
    else
      return {p, bcd_inc(h)};
  endfunction

  // Next-state and next-time logic; mode changes take priority over tick and increment.
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pm_d    = pm_q;
    day_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d = SET_HR;
          sec_d   = 8'h00;
        end else if (tick_1hz) begin
          if (sec_q == 8'h59) begin
            sec_d = 8'h00;
            if (min_q == 8'h59) begin
              min_d          = 8'h00;
              {pm_d, hour_d} = hour_step(hour_q, pm_q);
              day_d          = FORMAT_24H ? (hour_q == 8'h23) : (hour_q == 8'h11 && pm_q);
            end else begin
              min_d = bcd_inc(min_q);
            end
          end else begin
            sec_d = bcd_inc(sec_q);
          end
        end
      end
      SET_HR: begin
        if (btn_mode)
          state_d = SET_MIN;
        else if (btn_inc)
          {pm_d, hour_d} = hour_step(hour_q, pm_q);
      end
      SET_MIN: begin
        if (btn_mode)
          state_d = RUN;
        else if (btn_inc)
          min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
      end
      default: state_d = RUN;
    endcase
  end

  // State and time registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hour_q  <= HOUR_RESET;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      pm_q    <= 1'b0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pm_q    <= pm_d;
      day_q   <= day_d;
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign pm        = pm_q;
  assign mode      = state_q;
  assign day_tick  = day_q;
  assign blank_hr  = (state_q == SET_HR) & blink;
  assign blank_min = (state_q == SET_MIN) & blink;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper in 24h and 12h formats
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0;
  logic blink = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  logic [7:0] h24_hour, h24_min, h24_sec;
  logic       h24_pm, h24_bhr, h24_bmin, h24_day;
  logic [1:0] h24_mode;
  logic [7:0] h12_hour, h12_min, h12_sec;
  logic       h12_pm, h12_bhr, h12_bmin, h12_day;
  logic [1:0] h12_mode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  time_keeper #(.FORMAT_24H(1'b1)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .blink(blink),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_bcd(h24_hour), .min_bcd(h24_min), .sec_bcd(h24_sec), .pm(h24_pm),
    .mode(h24_mode), .blank_hr(h24_bhr), .blank_min(h24_bmin), .day_tick(h24_day)
  );

  time_keeper #(.FORMAT_24H(1'b0)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .blink(blink),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour_bcd(h12_hour), .min_bcd(h12_min), .sec_bcd(h12_sec), .pm(h12_pm),
    .mode(h12_mode), .blank_hr(h12_bhr), .blank_min(h12_bmin), .day_tick(h12_day)
  );

  // Model: time of day as plain integers on a 24-hour scale; both DUTs display the same instant.
  int   m_h, m_m, m_s, m_mode;
  logic m_day;

  function automatic int sod(input int h, input int m, input int s);
    return (h * 60 + m) * 60 + s;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int hour12(input int h);
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h <= 0; m_m <= 0; m_s <= 0; m_mode <= 0; m_day <= 1'b0;
    end else begin
      m_day <= 1'b0;
      case (m_mode)
        0: if (btn_mode) begin
             m_mode <= 1; m_s <= 0;
           end else if (tick_1hz) begin
             m_h   <= ((sod(m_h, m_m, m_s) + 1) % 86400) / 3600;
             m_m   <= (((sod(m_h, m_m, m_s) + 1) % 86400) / 60) % 60;
             m_s   <= ((sod(m_h, m_m, m_s) + 1) % 86400) % 60;
             m_day <= (sod(m_h, m_m, m_s) + 1 == 86400);
           end
        1: if (btn_mode) m_mode <= 2; else if (btn_inc) m_h <= (m_h + 1) % 24;
        2: if (btn_mode) m_mode <= 0; else if (btn_inc) m_m <= (m_m + 1) % 60;
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("h24.hour", h24_hour, to_bcd(m_h));
      chk("h24.min",  h24_min,  to_bcd(m_m));
      chk("h24.sec",  h24_sec,  to_bcd(m_s));
      chk("h24.pm",   h24_pm,   0);
      chk("h24.mode", h24_mode, m_mode);
      chk("h24.day",  h24_day,  m_day);
      chk("h24.bhr",  h24_bhr,  (m_mode == 1) && blink);
      chk("h24.bmin", h24_bmin, (m_mode == 2) && blink);
      chk("h12.hour", h12_hour, to_bcd(hour12(m_h)));
      chk("h12.min",  h12_min,  to_bcd(m_m));
      chk("h12.sec",  h12_sec,  to_bcd(m_s));
      chk("h12.pm",   h12_pm,   m_h >= 12);
      chk("h12.mode", h12_mode, m_mode);
      chk("h12.day",  h12_day,  m_day);
      chk("h12.bhr",  h12_bhr,  (m_mode == 1) && blink);
      chk("h12.bmin", h12_bmin, (m_mode == 2) && blink);
    end
  end

  // Inputs change 1 ns after a rising edge and are consumed at the next one.
  task automatic pulse(input logic bm, input logic bi, input logic tk);
    btn_mode = bm; btn_inc = bi; tick_1hz = tk;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset values and first-tick latency.
    do_reset();
    chk("rst.h24.hour", h24_hour, 8'h00);
    chk("rst.h12.hour", h12_hour, 8'h12);
    chk("rst.h12.pm", h12_pm, 1'b0);
    chk("rst.mode", h24_mode, 2'd0);
    btn_inc = 1'b1; @(posedge clk); #1 btn_inc = 1'b0;
    chk("run.inc_ignored", h24_hour, 8'h00);
    tick_1hz = 1'b1; #2;
    chk("tick.pre_edge", h24_sec, 8'h00);
    @(posedge clk); #1 tick_1hz = 1'b0;
    chk("tick.post_edge", h24_sec, 8'h01);
    ticks(2);
    chk("t3.sec", h24_sec, 8'h03);
    chk("t3.min", h24_min, 8'h00);

    // 23:59 preload, then a full minute to midnight.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    incs(23);
    pulse(1'b1, 1'b0, 1'b0);
    incs(59);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pre.h24.hour", h24_hour, 8'h23);
    chk("pre.h12.hour", h12_hour, 8'h11);
    chk("pre.h12.pm", h12_pm, 1'b1);
    ticks(59);
    chk("t59.sec", h24_sec, 8'h59);
    ticks(1);
    chk("mid.h24", {h24_hour, h24_min, h24_sec}, 24'h000000);
    chk("mid.h12", {h12_pm, h12_hour, h12_min, h12_sec}, 25'h0120000);
    chk("mid.day24", h24_day, 1'b1);
    chk("mid.day12", h12_day, 1'b1);
    @(posedge clk); #1;
    chk("mid.day_off", h24_day, 1'b0);

    // 12-hour hour setting across 11 -> 12 -> 01.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    incs(11);
    chk("s12.h11", {h12_pm, h12_hour}, 9'h011);
    incs(1);
    chk("s12.h12", {h12_pm, h12_hour}, 9'h112);
    incs(1);
    chk("s12.h01", {h12_pm, h12_hour}, 9'h101);
    chk("s12.h24", h24_hour, 8'h13);

    // 10:20:35, freeze in set mode, blink, min wrap, simultaneous buttons.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    incs(10);
    pulse(1'b1, 1'b0, 1'b0);
    incs(20);
    pulse(1'b1, 1'b0, 1'b0);
    ticks(35);
    chk("run.time", {h24_hour, h24_min, h24_sec}, 24'h102035);
    pulse(1'b1, 1'b0, 1'b1);
    chk("sethr.mode", h24_mode, 2'd1);
    chk("sethr.sec", h24_sec, 8'h00);
    ticks(5);
    chk("sethr.frozen", {h24_hour, h24_min, h24_sec}, 24'h102000);
    blink = 1'b1; #1;
    chk("blink.hr1", h24_bhr, 1'b1);
    chk("blink.min1", h24_bmin, 1'b0);
    blink = 1'b0; #1;
    chk("blink.hr0", h24_bhr, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    incs(39);
    chk("setmin.59", h24_min, 8'h59);
    incs(1);
    chk("setmin.wrap", {h24_hour, h24_min}, 16'h1000);
    pulse(1'b1, 1'b1, 1'b0);
    chk("both.mode", h24_mode, 2'd0);
    chk("both.min", h24_min, 8'h00);
    ticks(1);
    chk("resume.sec", h24_sec, 8'h01);

    // Asynchronous reset while setting minutes at 07:45:00.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    incs(7);
    pulse(1'b1, 1'b0, 1'b0);
    incs(45);
    blink = 1'b1; #1;
    chk("pre_rst.bmin", h24_bmin, 1'b1);
    chk("pre_rst.time", {h24_hour, h24_min, h24_sec}, 24'h074500);
    #2 rst_n = 1'b0; #1;
    chk("arst.h24", {h24_hour, h24_min, h24_sec}, 24'h000000);
    chk("arst.h12", h12_hour, 8'h12);
    chk("arst.mode", h24_mode, 2'd0);
    chk("arst.bmin", h24_bmin, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    blink = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
